// File: rtl/alu_4_seq.sv
// alu_4_seq: issue-side sequencer for the pipelined 4-bit alu_4 ALU.
//
// Accepts a WIDTH-bit request (req_*) over valid/ready. Feeds the operands to the
// ALU one nibble at a time, least significant first, and chains Carry_out into
// the next nibble's Carry_in for ADD. Returns the assembled result on rsp_* over
// valid/ready.
//
// Ports:
//   gclk, rst              clock, synchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_op                 00 XOR, 01 AND, 10 ADD, 11 reserved (rsp_err)
//   req_x, req_y           operands
//   req_cmpl_x/y           complement X/Y inside the ALU
//   req_carry_in           initial carry (ADD)
//   rsp_valid/rsp_ready    response handshake
//   rsp_data, rsp_carry    result and final carry (carry 0 for logic ops)
//   rsp_err                reserved opcode flag
//   alu_*                  ALU input bus (all 0 outside issue cycles)
//   alu_z, alu_carry_out   ALU outputs, valid ALU_LATENCY cycles after issue
//
// Optional build macro ALU4_SEQ_PIPE_LOGIC_EN: XOR/AND issue all nibbles
// back-to-back. ADD always runs serially because each nibble needs the previous carry.
module alu_4_seq #(
    parameter int WIDTH       = 16,
    parameter int ALU_LATENCY = 8
) (
    input  logic             gclk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    input  logic             req_cmpl_x,
    input  logic             req_cmpl_y,
    input  logic             req_carry_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [3:0]       alu_x,
    output logic [3:0]       alu_y,
    output logic             alu_carry_in,
    output logic             alu_end_bar,
    output logic             alu_cmpl_x,
    output logic             alu_cmpl_y,
    output logic             alu_op_xor,
    output logic             alu_op_and,
    output logic             alu_op_arith,
    input  logic [3:0]       alu_z,
    input  logic             alu_carry_out
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(ALU_LATENCY + N + 1) + 1;

    localparam logic [KW-1:0] LAST = KW'(N - 1);
    localparam logic [CW-1:0] LAT  = CW'(ALU_LATENCY);

    localparam logic [1:0] OP_XOR = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

`ifdef ALU4_SEQ_PIPE_LOGIC_EN
    localparam logic PIPE_LOGIC = 1'b1;
`else
    localparam logic PIPE_LOGIC = 1'b0;
`endif

    typedef enum logic [2:0] {DRAIN, IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, next_state;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] x_q, y_q;
    logic             cmpl_x_q, cmpl_y_q, cin_q;
    logic             pipe_q;
    logic [KW-1:0]    k;
    logic [KW-1:0]    cap_k;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic [WIDTH-1:0] data_q;
    logic             capture;
    logic [KW-1:0]    cap_idx;

    always_ff @(posedge gclk) begin
        if (rst) begin
            state <= DRAIN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        capture      = 1'b0;
        req_ready    = 1'b0;
        alu_x        = '0;
        alu_y        = '0;
        alu_carry_in = 1'b0;
        alu_end_bar  = 1'b0;
        alu_cmpl_x   = 1'b0;
        alu_cmpl_y   = 1'b0;
        alu_op_xor   = 1'b0;
        alu_op_and   = 1'b0;
        alu_op_arith = 1'b0;
        rsp_valid    = (state == RESP);
        rsp_data     = data_q;
        rsp_carry    = (state == RESP) && (op_q == OP_ADD) && carry_q;
        rsp_err      = (state == RESP) && (op_q == OP_RSV);

        unique case (state)
            DRAIN: begin
                if (cnt == LAT - 1'b1) next_state = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = (req_op == OP_RSV) ? RESP : ISSUE;
            end
            ISSUE: begin
                alu_x        = x_q[4*k +: 4];
                alu_y        = y_q[4*k +: 4];
                alu_cmpl_x   = cmpl_x_q;
                alu_cmpl_y   = cmpl_y_q;
                alu_op_xor   = (op_q == OP_XOR);
                alu_op_and   = (op_q == OP_AND);
                alu_op_arith = (op_q == OP_ADD);
                alu_end_bar  = (k != LAST);
                alu_carry_in = (op_q == OP_ADD) && ((k == '0) ? cin_q : carry_q);
                if (pipe_q) begin
                    // Early captures can overlap issue when the latency is shorter than N.
                    capture = (cnt >= LAT);
                    if (k == LAST) next_state = WAIT;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (pipe_q) begin
                    capture = (cnt >= LAT);
                    if (capture && cap_k == LAST) next_state = RESP;
                end else begin
                    capture = (cnt == LAT);
                    if (capture) next_state = (k == LAST) ? RESP : ISSUE;
                end
            end
            RESP: begin
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = DRAIN;
        endcase
    end

    assign cap_idx = pipe_q ? cap_k : k;

    always_ff @(posedge gclk) begin
        if (rst) begin
            op_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            cmpl_x_q <= 1'b0;
            cmpl_y_q <= 1'b0;
            cin_q    <= 1'b0;
            pipe_q   <= 1'b0;
            k        <= '0;
            cap_k    <= '0;
            cnt      <= '0;
            carry_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            unique case (state)
                DRAIN: cnt <= cnt + 1'b1;
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        x_q      <= req_x;
                        y_q      <= req_y;
                        cmpl_x_q <= req_cmpl_x;
                        cmpl_y_q <= req_cmpl_y;
                        cin_q    <= req_carry_in;
                        pipe_q   <= PIPE_LOGIC && (req_op == OP_XOR || req_op == OP_AND);
                        k        <= '0;
                        cap_k    <= '0;
                        cnt      <= '0;
                        carry_q  <= 1'b0;
                        data_q   <= '0;
                    end
                end
                ISSUE: begin
                    if (pipe_q) begin
                        // Issue is back-to-back, so one counter of cycles since the
                        // first issue stands in for a per-nibble age counter:
                        // nibble j is due when cnt == ALU_LATENCY + j.
                        cnt <= cnt + 1'b1;
                        if (k != LAST) k <= k + 1'b1;
                    end else begin
                        cnt <= CW'(1);
                    end
                end
                WAIT: begin
                    if (pipe_q || !capture) cnt <= cnt + 1'b1;
                    else if (k != LAST)     k   <= k + 1'b1;
                end
                default: ;
            endcase

            if (capture) begin
                data_q[4*cap_idx +: 4] <= alu_z;
                carry_q                <= alu_carry_out;
                if (pipe_q && cap_k != LAST) cap_k <= cap_k + 1'b1;
            end
        end
    end

endmodule
